ex_alu_unit: RTL and testbench

//  Execute-stage ALU. Sits directly downstream of the ALU A/B operand muxes and

---
 rtl/ex_alu_unit.sv | 174 +++++++++++++++++
 tb/tb_ex_alu_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage ALU fed by the A/B operand muxes.
//   Single-cycle ops register result/flags at the accept edge. out_valid then pulses for
//   one cycle. The optional MUL op (opcode C) is an iterative shift-add multiply. It takes
//   DATA_W cycles, and busy stays high for that whole time.
// Configuration macro: EX_ALU_MUL_EN. When it is undefined, opcode C is a single-cycle op
//   with result 0, and busy is tied low.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   flush            synchronous abort of any operation in flight
//   in_valid         operands/op valid this cycle
//   alu_op[3:0]      operation code
//   alu_a, alu_b     operands
//   busy             multi-cycle op running; upstream must stall
//   out_valid        one-cycle pulse when result/flags update
//   result           registered result
//   flag_z/c/v       zero, carry (ADD) / no-borrow (SUB), signed overflow (ADD/SUB)
module ex_alu_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v
);

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_SRA   = 4'h8;
  localparam logic [3:0] OP_SLT   = 4'h9;
  localparam logic [3:0] OP_EQ    = 4'hA;
  localparam logic [3:0] OP_PASSB = 4'hB;

  logic [DATA_W-1:0] result_q;
  logic              out_valid_q, flag_z_q, flag_c_q, flag_v_q;

  // Single-cycle datapath
  logic [DATA_W:0]          add_sum, sub_sum;
  logic [SHAMT_W-1:0]       shamt;
  logic signed [DATA_W-1:0] sra_res;
  logic                     slt;
  logic [DATA_W-1:0]        alu_res;
  logic                     alu_c, alu_v;

  assign shamt   = alu_b[SHAMT_W-1:0];
  assign add_sum = {1'b0, alu_a} + {1'b0, alu_b};
  // Subtract as a + ~b + 1 so that the carry-out reads as "no borrow"
  assign sub_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + (DATA_W+1)'(1);
  assign sra_res = $signed(alu_a) >>> shamt;
  assign slt     = $signed(alu_a) < $signed(alu_b);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = add_sum[DATA_W-1:0];
        alu_c   = add_sum[DATA_W];
        alu_v   = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                  (add_sum[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = sub_sum[DATA_W-1:0];
        alu_c   = sub_sum[DATA_W];
        alu_v   = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                  (sub_sum[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_AND:   alu_res = alu_a & alu_b;
      OP_OR:    alu_res = alu_a | alu_b;
      OP_XOR:   alu_res = alu_a ^ alu_b;
      OP_NOT:   alu_res = ~alu_a;
      OP_SLL:   alu_res = alu_a << shamt;
      OP_SRL:   alu_res = alu_a >> shamt;
      OP_SRA:   alu_res = sra_res;
      OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, slt};
      OP_EQ:    alu_res = {{(DATA_W-1){1'b0}}, (alu_a == alu_b)};
      OP_PASSB: alu_res = alu_b;
      default:  alu_res = '0;  // MUL (handled by the FSM when enabled), and D-F
    endcase
  end

`ifdef EX_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]         state_q;
  logic [DATA_W-1:0]  mcand_q, mplier_q, acc_q, acc_next;
  logic [SHAMT_W-1:0] count_q;

  // The final step's add must be visible in the result written on that same edge
  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign busy     = (state_q == ST_MUL);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
`ifdef EX_ALU_MUL_EN
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
`endif
    end else if (flush) begin
      // Abort; result and flags keep their last values
      out_valid_q <= 1'b0;
`ifdef EX_ALU_MUL_EN
      state_q     <= ST_IDLE;
`endif
    end else begin
      out_valid_q <= 1'b0;
`ifdef EX_ALU_MUL_EN
      if (state_q == ST_MUL) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        count_q  <= count_q + SHAMT_W'(1);
        if (count_q == SHAMT_W'(DATA_W - 1)) begin
          state_q     <= ST_IDLE;
          result_q    <= acc_next;
          flag_z_q    <= (acc_next == '0);
          flag_c_q    <= 1'b0;
          flag_v_q    <= 1'b0;
          out_valid_q <= 1'b1;
        end
      end else if (in_valid && (alu_op == OP_MUL)) begin
        state_q  <= ST_MUL;
        mcand_q  <= alu_a;
        mplier_q <= alu_b;
        acc_q    <= '0;
        count_q  <= '0;
      end else
`endif
      if (in_valid) begin
        result_q    <= alu_res;
        flag_z_q    <= (alu_res == '0);
        flag_c_q    <= alu_c;
        flag_v_q    <= alu_v;
        out_valid_q <= 1'b1;
      end
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
module tb_ex_alu_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        busy, out_valid, flag_z, flag_c, flag_v;
  logic [15:0] result;

  ex_alu_unit #(.DATA_W(16), .SHAMT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .busy      (busy),
    .out_valid (out_valid),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] res;
    logic        z, c, v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one op for one accept edge and queue its expected response
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic z, input logic c, input logic v);
    exp_t e;
    e.op = op; e.res = res; e.z = z; e.c = c; e.v = v;
    exp_q.push_back(e);
    alu_op = op; alu_a = a; alu_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every out_valid pulse is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", {16'h0, result}, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("op%0h_result", e.op), {16'h0, result}, {16'h0, e.res});
          chk($sformatf("op%0h_flag_z", e.op), {31'h0, flag_z}, {31'h0, e.z});
          chk($sformatf("op%0h_flag_c", e.op), {31'h0, flag_c}, {31'h0, e.c});
          chk($sformatf("op%0h_flag_v", e.op), {31'h0, flag_v}, {31'h0, e.v});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_op = 4'h0; alu_a = '0; alu_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy",      {31'h0, busy},      32'h0);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_result",    {16'h0, result},    32'h0);
    chk("reset_flags",     {29'h0, flag_z, flag_c, flag_v}, 32'h0);

    // Signed overflow on ADD, then check pulse width is one cycle
    issue(4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("add_pulse_width", {31'h0, out_valid}, 32'h0);

    // Back-to-back single-cycle ops
    issue(4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0);
    issue(4'h8, 16'h8000, 16'h0003, 16'hF000, 1'b0, 1'b0, 1'b0);
    issue(4'h1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    issue(4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1);
    issue(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
    issue(4'h2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0);
    issue(4'h3, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 1'b0);
    issue(4'h4, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1'b0);
    issue(4'h5, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0);
    issue(4'h6, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0);  // upper b bits ignored
    issue(4'h7, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0, 1'b0);
    issue(4'h9, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(4'h9, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    issue(4'hA, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(4'hB, 16'h0000, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0);
    issue(4'hE, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0);
    issue(4'h0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0);

    // Reset pulse with a same-cycle op: op dropped, state cleared
    rst = 1'b1; in_valid = 1'b1; alu_op = 4'h0; alu_a = 16'h0101; alu_b = 16'h0202;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_mid_busy",      {31'h0, busy},      32'h0);
    chk("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_result",    {16'h0, result},    32'h0);

    // Flush with a same-cycle op: op not accepted, no pulse
    flush = 1'b1; in_valid = 1'b1; alu_op = 4'h0; alu_a = 16'h0007; alu_b = 16'h0007;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_blocks_accept", {31'h0, out_valid}, 32'h0);

`ifdef EX_ALU_MUL_EN
    begin
      int busy_cnt;
      int ov_at;
      busy_cnt = 0;
      ov_at    = -1;
      issue(4'hC, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40 && ov_at < 0; i++) begin
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        if (out_valid === 1'b1) ov_at = i;
        // Ops offered while busy must be ignored
        in_valid = busy;
        alu_op = 4'h0; alu_a = 16'h0100; alu_b = 16'h0200;
      end
      in_valid = 1'b0;
      chk("mul_busy_cycles", busy_cnt, 16);
      chk("mul_out_valid_cycle", ov_at, 16);
    end

    // Flush mid-MUL: discarded, busy drops, no pulse
    issue(4'hC, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; alu_op = 4'h0; alu_a = 16'h0005; alu_b = 16'h0005;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_mul_busy",      {31'h0, busy},      32'h0);
    chk("flush_mul_out_valid", {31'h0, out_valid}, 32'h0);
    repeat (20) @(posedge clk);
    #1;
`else
    // MUL not built: single-cycle, zero result, never busy
    issue(4'hC, 16'h0003, 16'h0004, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("mul_off_busy", {31'h0, busy}, 32'h0);
`endif

    issue(4'h0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
